// File: rtl/jt1943_prog_fmt.sv
// jt1943_prog_fmt: ROM download formatter.
// Maps each downloaded byte into the SDRAM layout or onto the on-chip PROM
// write strobes. SDRAM bytes pass through a 2-entry buffer to the
// prog_we/prog_ack handshake.
// Optional feature macro: JT1943_PROG_CHECKSUM_EN (16-bit byte sum on checksum).
module jt1943_prog_fmt #(
  parameter logic [21:0] SNDADDR  = 22'h28000,
  parameter logic [21:0] CHARADDR = 22'h30000,
  parameter logic [21:0] SCRADDR  = 22'h38000,
  parameter logic [21:0] SCR_HALF = 22'h40000,
  parameter logic [21:0] OBJADDR  = 22'hB8000,
  parameter logic [21:0] OBJ_HALF = 22'h20000,
  parameter logic [21:0] PROMADDR = 22'hF8000,
  parameter int unsigned PROM_CNT = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                ioctl_wr,
  input  logic [21:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  output logic                prog_we,
  output logic [21:0]         prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  input  logic                prog_ack,
  output logic [PROM_CNT-1:0] prom_we,
  output logic [7:0]          prom_addr,
  output logic [3:0]          prom_data,
  output logic                prog_done,
  output logic                overflow,
  output logic [15:0]         checksum
);

  typedef enum logic [1:0] {REG_LIN, REG_SCR, REG_OBJ, REG_PROM} region_t;

  logic                r_s1_valid;
  logic [21:0]         r_s1_addr;
  logic [7:0]          r_s1_data;
  logic                r_dl_d;
  logic                r_overflow;
  logic [21:0]         r_addr [2];
  logic [7:0]          r_data [2];
  logic [1:0]          r_mask [2];
  logic                r_rd;
  logic                r_wr;
  logic [1:0]          r_cnt;
  logic [PROM_CNT-1:0] r_prom_we;
  logic [7:0]          r_prom_addr;
  logic [3:0]          r_prom_data;

  region_t             w_region;
  logic [21:0]         w_off;
  logic [21:0]         w_wr_addr;
  logic [1:0]          w_wr_mask;
  logic [13:0]         w_prom_idx;
  logic                w_prom_ok;
  logic [PROM_CNT-1:0] w_prom_onehot;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_acc;
  logic                w_drop;
  logic                w_dl_rise;

  // Region decode, highest base first, and SDRAM address/lane remap
  always_comb begin
    w_region  = REG_LIN;
    w_off     = '0;
    w_wr_addr = {1'b0, r_s1_addr[21:1]};
    w_wr_mask = r_s1_addr[0] ? 2'b01 : 2'b10;
    if (r_s1_addr >= PROMADDR) begin
      w_region = REG_PROM;
      w_off    = r_s1_addr - PROMADDR;
    end else if (r_s1_addr >= OBJADDR) begin
      w_region  = REG_OBJ;
      w_off     = r_s1_addr - OBJADDR;
      // halves interleave onto one word: first half low lane, second half high lane
      w_wr_addr = (OBJADDR >> 1) + (w_off & (OBJ_HALF - 22'd1));
      w_wr_mask = (w_off >= OBJ_HALF) ? 2'b01 : 2'b10;
    end else if (r_s1_addr >= SCRADDR) begin
      w_region  = REG_SCR;
      w_off     = r_s1_addr - SCRADDR;
      w_wr_addr = (SCRADDR >> 1) + (w_off & (SCR_HALF - 22'd1));
      w_wr_mask = (w_off >= SCR_HALF) ? 2'b01 : 2'b10;
    end
  end

  assign w_prom_idx    = w_off[21:8];
  assign w_prom_ok     = (w_prom_idx < 14'(PROM_CNT));
  assign w_prom_onehot = PROM_CNT'(1) << w_prom_idx;

  assign w_full    = (r_cnt == 2'd2);
  assign w_pop     = prog_ack & (r_cnt != 2'd0);
  assign w_push    = r_s1_valid & (w_region != REG_PROM);
  assign w_acc     = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_dl_rise = downloading & ~r_dl_d;

  // Stage 1: capture accepted download strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= ioctl_wr & downloading;
      if (ioctl_wr & downloading) begin
        r_s1_addr <= ioctl_addr;
        r_s1_data <= ioctl_data;
      end
    end
  end

  // 2-entry buffer; when full, a pop frees the head slot the push reuses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '1;
      end
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_addr[r_wr] <= w_wr_addr;
        r_data[r_wr] <= r_s1_data;
        r_mask[r_wr] <= w_wr_mask;
        r_wr         <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_acc} - {1'b0, w_pop};
    end
  end

  // PROM strobe: one-cycle pulse, out-of-range PROM index discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prom_we   <= '0;
      r_prom_addr <= '0;
      r_prom_data <= '0;
    end else begin
      r_prom_we <= '0;
      if (r_s1_valid && w_region == REG_PROM && w_prom_ok) begin
        r_prom_we   <= w_prom_onehot;
        r_prom_addr <= w_off[7:0];
        r_prom_data <= r_s1_data[3:0];
      end
    end
  end

  // Sticky overflow, cleared when a new download starts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_d     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_dl_d <= downloading;
      if (w_dl_rise)   r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef JT1943_PROG_CHECKSUM_EN
  logic [15:0] r_sum;
  logic        w_sum_en;

  assign w_sum_en = w_acc | (r_s1_valid & (w_region == REG_PROM) & w_prom_ok);

  // Running sum of every byte that reached the buffer or a PROM
  always_ff @(posedge clk) begin
    if (rst)           r_sum <= '0;
    else if (w_dl_rise) r_sum <= '0;
    else if (w_sum_en)  r_sum <= r_sum + {8'h00, r_s1_data};
  end

  assign checksum = r_sum;
`else
  assign checksum = '0;
`endif

  assign prog_we   = (r_cnt != 2'd0);
  assign prog_addr = r_addr[r_rd];
  assign prog_data = r_data[r_rd];
  assign prog_mask = r_mask[r_rd];
  assign prom_we   = r_prom_we;
  assign prom_addr = r_prom_addr;
  assign prom_data = r_prom_data;
  assign prog_done = ~downloading & (r_cnt == 2'd0) & ~r_s1_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_jt1943_prog_fmt.sv
// Scoreboard bench for jt1943_prog_fmt: expected SDRAM writes and PROM
// strobes are queued by the stimulus and checked by a negedge monitor.
module tb_jt1943_prog_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic        ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        prog_we;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_ack;
  logic [9:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_data;
  logic        prog_done;
  logic        overflow;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [21:0] a; logic [7:0] d; logic [1:0] m;} pexp_t;
  typedef struct {logic [9:0] we; logic [7:0] a; logic [3:0] d;} rexp_t;
  pexp_t pq[$];
  rexp_t rq[$];

  jt1943_prog_fmt dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(prog_ack), .prom_we(prom_we), .prom_addr(prom_addr),
    .prom_data(prom_data), .prog_done(prog_done), .overflow(overflow),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [21:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  function automatic void exp_prog(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    pexp_t e;
    e.a = a; e.d = d; e.m = m;
    pq.push_back(e);
  endfunction

  function automatic void exp_prom(input logic [9:0] we, input logic [7:0] a, input logic [3:0] d);
    rexp_t e;
    e.we = we; e.a = a; e.d = d;
    rq.push_back(e);
  endfunction

  // Monitor: every accepted SDRAM write and every PROM pulse must match the queue head
  initial begin
    pexp_t p;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (prog_we && prog_ack) begin
        if (pq.size() == 0) chk("prog_unexpected", {10'h0, prog_addr}, 32'hFFFFFFFF);
        else begin
          p = pq.pop_front();
          chk("prog_addr", {10'h0, prog_addr}, {10'h0, p.a});
          chk("prog_data", {24'h0, prog_data}, {24'h0, p.d});
          chk("prog_mask", {30'h0, prog_mask}, {30'h0, p.m});
        end
      end
      if (prom_we != 10'h0) begin
        if (rq.size() == 0) chk("prom_unexpected", {22'h0, prom_we}, 32'h0);
        else begin
          r = rq.pop_front();
          chk("prom_we", {22'h0, prom_we}, {22'h0, r.we});
          chk("prom_addr", {24'h0, prom_addr}, {24'h0, r.a});
          chk("prom_data", {28'h0, prom_data}, {28'h0, r.d});
        end
      end
    end
  end

  initial begin
    logic [15:0] exp_sum;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0; prog_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // Reset state
    chk("rst_prog_we", {31'h0, prog_we}, 32'h0);
    chk("rst_prom_we", {22'h0, prom_we}, 32'h0);
    chk("rst_prog_addr", {10'h0, prog_addr}, 32'h0);
    chk("rst_prog_data", {24'h0, prog_data}, 32'h0);
    chk("rst_prog_mask", {30'h0, prog_mask}, 32'h3);
    chk("rst_prom_addr", {24'h0, prom_addr}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_checksum", {16'h0, checksum}, 32'h0);
    chk("rst_prog_done", {31'h0, prog_done}, 32'h1);

    // CPU byte with 2-cycle latency
    downloading = 1'b1;
    tick();
    chk("dl_prog_done", {31'h0, prog_done}, 32'h0);
    exp_prog(22'h00002, 8'hA5, 2'b01);
    strobe(22'h00005, 8'hA5);
    chk("lat1_prog_we", {31'h0, prog_we}, 32'h0);
    tick();
    chk("lat2_prog_we", {31'h0, prog_we}, 32'h1);
    chk("lat2_prog_addr", {10'h0, prog_addr}, 32'h00002);
    chk("lat2_prog_mask", {30'h0, prog_mask}, 32'h1);
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    chk("ack_prog_we", {31'h0, prog_we}, 32'h0);
    downloading = 1'b0;
    tick();
    chk("cpu_prog_done", {31'h0, prog_done}, 32'h1);

    // Region remap burst with ack held high (one byte per cycle)
    downloading = 1'b1;
    tick();
    exp_prog(22'h5C000, 8'h11, 2'b10);   // OBJ first half
    exp_prog(22'h5C000, 8'h22, 2'b01);   // OBJ second half
    exp_prog(22'h1C005, 8'h33, 2'b10);   // SCR offset 5
    exp_prog(22'h1C007, 8'h44, 2'b01);   // SCR second half offset 7
    exp_prog(22'h14001, 8'h55, 2'b01);   // sound, odd byte
    exp_prog(22'h18000, 8'h66, 2'b10);   // char, even byte
    exp_prog(22'h5C010, 8'h77, 2'b10);   // OBJ offset 0x10
    prog_ack = 1'b1;
    strobe(22'hB8000, 8'h11);
    strobe(22'hD8000, 8'h22);
    strobe(22'h38005, 8'h33);
    strobe(22'h78007, 8'h44);
    strobe(22'h28003, 8'h55);
    strobe(22'h30000, 8'h66);
    strobe(22'hB8010, 8'h77);
    tick(); tick(); tick();
    prog_ack = 1'b0;
    chk("burst_overflow", {31'h0, overflow}, 32'h0);

    // PROM strobes
    exp_prom(10'b0000001000, 8'h12, 4'hC);
    strobe(22'hF8312, 8'h3C);
    tick();
    chk("prom3_we", {22'h0, prom_we}, 32'h008);
    chk("prom3_prog_we", {31'h0, prog_we}, 32'h0);
    tick();
    chk("prom3_pulse_end", {22'h0, prom_we}, 32'h0);
    strobe(22'hF8A00, 8'h55);
    tick();
    chk("prom_oor_we", {22'h0, prom_we}, 32'h0);
    exp_prom(10'b1000000000, 8'hFF, 4'h7);
    strobe(22'hF89FF, 8'hA7);
    tick(); tick();
    chk("prom_prog_we", {31'h0, prog_we}, 32'h0);

    // Backpressure: 4 strobes, 2 kept, overflow set
    exp_prog(22'h00008, 8'h10, 2'b10);
    exp_prog(22'h00008, 8'h11, 2'b01);
    strobe(22'h00010, 8'h10);
    strobe(22'h00011, 8'h11);
    strobe(22'h00012, 8'h12);
    strobe(22'h00013, 8'h13);
    tick();
    chk("bp_overflow", {31'h0, overflow}, 32'h1);
    chk("bp_prog_we", {31'h0, prog_we}, 32'h1);
    downloading = 1'b0;
    tick();
    chk("bp_not_done", {31'h0, prog_done}, 32'h0);
    prog_ack = 1'b1;
    tick(); tick();
    prog_ack = 1'b0;
    chk("bp_drained", {31'h0, prog_we}, 32'h0);
    chk("bp_prog_done", {31'h0, prog_done}, 32'h1);
    chk("bp_overflow_sticky", {31'h0, overflow}, 32'h1);

    // Reset mid-drain: queued writes and overflow are discarded
    downloading = 1'b1;
    tick();
    chk("dl_rise_clears_ovf", {31'h0, overflow}, 32'h0);
    strobe(22'h00100, 8'h21);
    strobe(22'h00101, 8'h22);
    strobe(22'h00102, 8'h23);
    tick();
    chk("mid_overflow", {31'h0, overflow}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_prog_we", {31'h0, prog_we}, 32'h0);
    chk("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    chk("mid_ack_ignored", {31'h0, prog_we}, 32'h0);

    // Checksum over accepted bytes
    tick();
    exp_prog(22'h00000, 8'hFF, 2'b10);
    exp_prog(22'h00000, 8'h02, 2'b01);
    exp_prog(22'h00001, 8'h10, 2'b10);
    prog_ack = 1'b1;
    strobe(22'h00000, 8'hFF);
    strobe(22'h00001, 8'h02);
    strobe(22'h00002, 8'h10);
    tick(); tick(); tick();
    prog_ack = 1'b0;
`ifdef JT1943_PROG_CHECKSUM_EN
    exp_sum = 16'h0111;
`else
    exp_sum = 16'h0000;
`endif
    chk("checksum", {16'h0, checksum}, {16'h0, exp_sum});
    downloading = 1'b0;
    tick();
    chk("end_prog_done", {31'h0, prog_done}, 32'h1);

    for (int i = 0; i < 20 && (pq.size() != 0 || rq.size() != 0); i++) tick();
    chk("prog_queue_empty", pq.size(), 32'h0);
    chk("prom_queue_empty", rq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
